// File: rtl/stroke_pkg.sv
// rtl/stroke_pkg.sv - shared types and widths for the stroke capture block
package stroke_pkg;

    localparam int X_W   = 11;
    localparam int Y_W   = 10;
    localparam int CNT_W = 4;

    typedef logic [X_W-1:0]   x_coord_t;
    typedef logic [Y_W-1:0]   y_coord_t;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARM    = 2'd1,
        ST_TRACK  = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

endpackage

// File: rtl/coord_absdiff.sv
// rtl/coord_absdiff.sv - combinational unsigned |a-b| with one extra result bit
module coord_absdiff #(
    parameter int W = 11
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W:0]   diff
);

    logic [W:0] a_ext;
    logic [W:0] b_ext;

    always_comb begin
        a_ext = {1'b0, a};
        b_ext = {1'b0, b};
        diff  = (a_ext >= b_ext) ? (a_ext - b_ext) : (b_ext - a_ext);
    end

endmodule

// File: rtl/stroke_capture.sv
// rtl/stroke_capture.sv - per-frame pen-down/pen-up debounce producing a two-point stroke
module stroke_capture
    import stroke_pkg::*;
#(
    parameter int START_FRAMES = 3,
    parameter int END_FRAMES   = 4,
    parameter int JITTER       = 8,
    parameter int MIN_LEN      = 16
) (
    input  logic           clk_in,
    input  logic           rst_n_in,
    input  logic           enable_in,
    input  logic           frame_done_in,
    input  logic           marker_valid_in,
    input  logic [X_W-1:0] marker_x_in,
    input  logic [Y_W-1:0] marker_y_in,
    output logic [X_W-1:0] x_out_1,
    output logic [Y_W-1:0] y_out_1,
    output logic [X_W-1:0] x_out_2,
    output logic [Y_W-1:0] y_out_2,
    output logic           place_obj_out,
    output logic           drawing_out,
    output logic [1:0]     state_out
);

    localparam cnt_t         START_CNT = CNT_W'(START_FRAMES);
    localparam cnt_t         END_CNT   = CNT_W'(END_FRAMES);
    localparam logic [X_W:0] JIT_X     = (X_W+1)'(JITTER);
    localparam logic [Y_W:0] JIT_Y     = (Y_W+1)'(JITTER);
    localparam logic [X_W:0] LEN_X     = (X_W+1)'(MIN_LEN);

    state_t   state_q;
    state_t   state_d;
    x_coord_t cand_x;
    y_coord_t cand_y;
    cnt_t     arm_cnt;
    cnt_t     miss_cnt;

    logic [X_W:0] jit_dx;
    logic [Y_W:0] jit_dy;
    logic [X_W:0] len_dx;
    logic [Y_W:0] unused_len_dy;

    coord_absdiff #(.W(X_W)) u_jit_x (.a(marker_x_in), .b(cand_x),  .diff(jit_dx));
    coord_absdiff #(.W(Y_W)) u_jit_y (.a(marker_y_in), .b(cand_y),  .diff(jit_dy));
    coord_absdiff #(.W(X_W)) u_len_x (.a(x_out_2),     .b(x_out_1), .diff(len_dx));
    coord_absdiff #(.W(Y_W)) u_len_y (.a(y_out_2),     .b(y_out_1), .diff(unused_len_dy));

    cnt_t arm_next;
    cnt_t miss_next;
    logic in_jit;
    logic arm_done;
    logic miss_done;
    logic len_ok;

    always_comb begin
        arm_next  = arm_cnt + 1'b1;
        miss_next = miss_cnt + 1'b1;
        in_jit    = (jit_dx <= JIT_X) && (jit_dy <= JIT_Y);
        arm_done  = (arm_next == START_CNT);
        miss_done = (miss_next == END_CNT);
        len_ok    = (len_dx >= LEN_X);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!enable_in) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (frame_done_in && marker_valid_in) state_d = ST_ARM;
                end
                ST_ARM: begin
                    if (frame_done_in) begin
                        if (!marker_valid_in)         state_d = ST_IDLE;
                        else if (in_jit && arm_done)  state_d = ST_TRACK;
                    end
                end
                ST_TRACK: begin
                    if (frame_done_in && !marker_valid_in && miss_done)
                        state_d = len_ok ? ST_COMMIT : ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Gating with enable_in lets an abort landing on the COMMIT cycle swallow the pulse.
    always_comb begin
        place_obj_out = (state_q == ST_COMMIT) && enable_in;
        drawing_out   = (state_q == ST_TRACK);
        state_out     = state_q;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cand_x   <= '0;
            cand_y   <= '0;
            arm_cnt  <= '0;
            miss_cnt <= '0;
            x_out_1  <= '0;
            y_out_1  <= '0;
            x_out_2  <= '0;
            y_out_2  <= '0;
        end else if (!enable_in) begin
            arm_cnt  <= '0;
            miss_cnt <= '0;
        end else if (frame_done_in) begin
            case (state_q)
                ST_IDLE: begin
                    if (marker_valid_in) begin
                        cand_x  <= marker_x_in;
                        cand_y  <= marker_y_in;
                        arm_cnt <= CNT_W'(1);
                    end
                end
                ST_ARM: begin
                    if (!marker_valid_in) begin
                        arm_cnt <= '0;
                    end else if (in_jit) begin
                        if (arm_done) begin
                            x_out_1  <= cand_x;
                            y_out_1  <= cand_y;
                            x_out_2  <= marker_x_in;
                            y_out_2  <= marker_y_in;
                            arm_cnt  <= '0;
                            miss_cnt <= '0;
                        end else begin
                            arm_cnt <= arm_next;
                        end
                    end else begin
                        cand_x  <= marker_x_in;
                        cand_y  <= marker_y_in;
                        arm_cnt <= CNT_W'(1);
                    end
                end
                ST_TRACK: begin
                    if (marker_valid_in) begin
                        x_out_2  <= marker_x_in;
                        y_out_2  <= marker_y_in;
                        miss_cnt <= '0;
                    end else if (miss_done) begin
                        miss_cnt <= '0;
                    end else begin
                        miss_cnt <= miss_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stroke_capture.sv
// tb/tb_stroke_capture.sv - scoreboard bench for stroke_capture
module tb_stroke_capture;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        enable_in;
    logic        frame_done_in;
    logic        marker_valid_in;
    logic [10:0] marker_x_in;
    logic [9:0]  marker_y_in;
    logic [10:0] x_out_1;
    logic [9:0]  y_out_1;
    logic [10:0] x_out_2;
    logic [9:0]  y_out_2;
    logic        place_obj_out;
    logic        drawing_out;
    logic [1:0]  state_out;

    stroke_capture dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .enable_in       (enable_in),
        .frame_done_in   (frame_done_in),
        .marker_valid_in (marker_valid_in),
        .marker_x_in     (marker_x_in),
        .marker_y_in     (marker_y_in),
        .x_out_1         (x_out_1),
        .y_out_1         (y_out_1),
        .x_out_2         (x_out_2),
        .y_out_2         (y_out_2),
        .place_obj_out   (place_obj_out),
        .drawing_out     (drawing_out),
        .state_out       (state_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int x1;
        int y1;
        int x2;
        int y2;
    } commit_t;

    commit_t exp_q[$];
    int      n_tests = 0;
    int      n_fail  = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic frame(input logic v, input int x, input int y);
        @(negedge clk_in);
        frame_done_in   = 1'b1;
        marker_valid_in = v;
        marker_x_in     = 11'(x);
        marker_y_in     = 10'(y);
        @(negedge clk_in);
        frame_done_in   = 1'b0;
        marker_valid_in = 1'b0;
    endtask

    task automatic pen_down(input int x, input int y);
        repeat (3) frame(1'b1, x, y);
    endtask

    task automatic push_commit(input int x1, input int y1, input int x2, input int y2);
        commit_t c;
        c.x1 = x1; c.y1 = y1; c.x2 = x2; c.y2 = y2;
        exp_q.push_back(c);
    endtask

    always @(negedge clk_in) begin : commit_monitor
        commit_t e;
        if (rst_n_in && place_obj_out) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_pulse", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check_eq("commit_x1", int'(x_out_1), e.x1);
                check_eq("commit_y1", int'(y_out_1), e.y1);
                check_eq("commit_x2", int'(x_out_2), e.x2);
                check_eq("commit_y2", int'(y_out_2), e.y2);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n_in        = 1'b0;
        enable_in       = 1'b1;
        frame_done_in   = 1'b0;
        marker_valid_in = 1'b0;
        marker_x_in     = '0;
        marker_y_in     = '0;
        repeat (3) @(negedge clk_in);
        check_eq("rst_state",   int'(state_out), 0);
        check_eq("rst_x1",      int'(x_out_1), 0);
        check_eq("rst_y1",      int'(y_out_1), 0);
        check_eq("rst_x2",      int'(x_out_2), 0);
        check_eq("rst_y2",      int'(y_out_2), 0);
        check_eq("rst_place",   int'(place_obj_out), 0);
        check_eq("rst_drawing", int'(drawing_out), 0);
        rst_n_in = 1'b1;
        repeat (2) @(negedge clk_in);

        // pen-down debounce
        frame(1'b1, 100, 200);
        check_eq("pd_arm1", int'(state_out), 1);
        frame(1'b1, 100, 200);
        check_eq("pd_arm2", int'(state_out), 1);
        frame(1'b1, 100, 200);
        check_eq("pd_track",   int'(state_out), 2);
        check_eq("pd_drawing", int'(drawing_out), 1);
        check_eq("pd_x1", int'(x_out_1), 100);
        check_eq("pd_y1", int'(y_out_1), 200);
        check_eq("pd_x2", int'(x_out_2), 100);

        // commit after four misses
        frame(1'b1, 180, 210);
        check_eq("tr_x2", int'(x_out_2), 180);
        check_eq("tr_y2", int'(y_out_2), 210);
        repeat (3) frame(1'b0, 0, 0);
        check_eq("cm_still_track", int'(state_out), 2);
        check_eq("cm_no_pulse_yet", int'(place_obj_out), 0);
        push_commit(100, 200, 180, 210);
        frame(1'b0, 0, 0);
        check_eq("cm_pulse", int'(place_obj_out), 1);
        check_eq("cm_state", int'(state_out), 3);
        @(negedge clk_in);
        check_eq("cm_pulse_end", int'(place_obj_out), 0);
        check_eq("cm_idle",      int'(state_out), 0);
        check_eq("cm_hold_x1",   int'(x_out_1), 100);
        check_eq("cm_hold_x2",   int'(x_out_2), 180);

        // jitter restart
        frame(1'b1, 100, 200);
        frame(1'b1, 100, 200);
        frame(1'b1, 120, 200);
        frame(1'b1, 120, 200);
        check_eq("jr_arm", int'(state_out), 1);
        frame(1'b1, 120, 200);
        check_eq("jr_track", int'(state_out), 2);
        check_eq("jr_x1", int'(x_out_1), 120);
        check_eq("jr_y1", int'(y_out_1), 200);

        // miss recovery then commit with fresh miss count
        repeat (3) frame(1'b0, 0, 0);
        frame(1'b1, 150, 205);
        check_eq("mr_state", int'(state_out), 2);
        check_eq("mr_x2", int'(x_out_2), 150);
        check_eq("mr_y2", int'(y_out_2), 205);
        repeat (3) frame(1'b0, 0, 0);
        check_eq("mr_cleared", int'(state_out), 2);
        push_commit(120, 200, 150, 205);
        frame(1'b0, 0, 0);
        check_eq("mr_pulse", int'(place_obj_out), 1);
        repeat (2) @(negedge clk_in);

        // short stroke discarded
        pen_down(100, 200);
        frame(1'b1, 110, 200);
        repeat (4) frame(1'b0, 0, 0);
        check_eq("ss_state", int'(state_out), 0);
        check_eq("ss_place", int'(place_obj_out), 0);
        check_eq("ss_x2",    int'(x_out_2), 110);
        repeat (2) @(negedge clk_in);

        // jitter edge (exactly JITTER) and length edge (exactly MIN_LEN, leftward)
        frame(1'b1, 300, 100);
        frame(1'b1, 308, 108);
        frame(1'b1, 300, 100);
        check_eq("je_track", int'(state_out), 2);
        check_eq("je_x1", int'(x_out_1), 300);
        check_eq("je_y1", int'(y_out_1), 100);
        frame(1'b1, 284, 100);
        push_commit(300, 100, 284, 100);
        repeat (4) frame(1'b0, 0, 0);
        check_eq("le_pulse", int'(place_obj_out), 1);
        repeat (2) @(negedge clk_in);

        // enable drop during TRACK holds outputs
        pen_down(50, 60);
        frame(1'b1, 400, 70);
        enable_in = 1'b0;
        @(negedge clk_in);
        check_eq("en_state", int'(state_out), 0);
        check_eq("en_x1", int'(x_out_1), 50);
        check_eq("en_y1", int'(y_out_1), 60);
        check_eq("en_x2", int'(x_out_2), 400);
        check_eq("en_y2", int'(y_out_2), 70);
        check_eq("en_place", int'(place_obj_out), 0);
        enable_in = 1'b1;
        repeat (2) @(negedge clk_in);

        // asynchronous reset during TRACK zeroes everything at once
        pen_down(60, 70);
        check_eq("ar_track", int'(state_out), 2);
        #2 rst_n_in = 1'b0;
        #1;
        check_eq("ar_state",   int'(state_out), 0);
        check_eq("ar_x1",      int'(x_out_1), 0);
        check_eq("ar_y2",      int'(y_out_2), 0);
        check_eq("ar_drawing", int'(drawing_out), 0);
        check_eq("ar_place",   int'(place_obj_out), 0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        repeat (3) @(negedge clk_in);

        check_eq("sb_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
